// File: rtl/urv_writeback_pkg.sv
// Shared encodings for the uRV writeback stage: load/store width codes, rd source select, W FSM states.
package urv_writeback_pkg;

   localparam logic [2:0] LDST_B  = 3'b000;
   localparam logic [2:0] LDST_H  = 3'b001;
   localparam logic [2:0] LDST_L  = 3'b010;
   localparam logic [2:0] LDST_BU = 3'b100;
   localparam logic [2:0] LDST_HU = 3'b101;

   localparam logic [1:0] RD_SOURCE_ALU      = 2'd0;
   localparam logic [1:0] RD_SOURCE_SHIFTER  = 2'd1;
   localparam logic [1:0] RD_SOURCE_MULTIPLY = 2'd2;
   localparam logic [1:0] RD_SOURCE_CSR      = 2'd3;

   typedef enum logic [1:0] {
      WB_IDLE       = 2'd0,
      WB_WAIT_LOAD  = 2'd1,
      WB_WAIT_STORE = 2'd2
   } wb_state_t;

   function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
      return {{24{sgn & b[7]}}, b};
   endfunction

   function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
      return {{16{sgn & h[15]}}, h};
   endfunction

endpackage

// File: rtl/urv_load_align.sv
// Combinational load aligner: picks the byte/half lane from the word address and sign/zero-extends.
// Zero latency, no flow control.
module urv_load_align
   import urv_writeback_pkg::*;
(
   input  logic [2:0]  i_fun,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_data,
   output logic [31:0] o_value
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_data[7:0];
      case (i_addr)
         2'd0: w_byte = i_data[7:0];
         2'd1: w_byte = i_data[15:8];
         2'd2: w_byte = i_data[23:16];
         2'd3: w_byte = i_data[31:24];
         default: w_byte = i_data[7:0];
      endcase
      w_half = i_addr[1] ? i_data[31:16] : i_data[15:0];
   end

   always_comb begin
      o_value = i_data;
      case (i_fun)
         LDST_B:  o_value = ext_byte(w_byte, 1'b1);
         LDST_BU: o_value = ext_byte(w_byte, 1'b0);
         LDST_H:  o_value = ext_half(w_half, 1'b1);
         LDST_HU: o_value = ext_half(w_half, 1'b0);
         default: o_value = i_data;
      endcase
   end

endmodule

// File: rtl/urv_writeback.sv
// uRV W stage: waits for data-memory completion, aligns loads, writes the register file one edge after commit.
// Stall request is combinational; optional bus-timeout abort enabled by URV_WB_TIMEOUT_EN.
module urv_writeback
   import urv_writeback_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
)
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        x_stall_i,
   input  logic        w_valid_i,
   input  logic        w_load_i,
   input  logic        w_store_i,
   input  logic [2:0]  w_fun_i,
   input  logic [4:0]  w_rd_i,
   input  logic        w_rd_write_i,
   input  logic [1:0]  w_rd_source_i,
   input  logic [31:0] w_rd_value_i,
   input  logic [31:0] w_rd_shifter_i,
   input  logic [31:0] w_rd_multiply_i,
   input  logic [31:0] w_dm_addr_i,
   input  logic [31:0] dm_data_l_i,
   input  logic        dm_load_done_i,
   input  logic        dm_store_done_i,
   output logic        w_stall_req_o,
   output logic [4:0]  rf_rd_o,
   output logic [31:0] rf_rd_value_o,
   output logic        rf_rd_write_o,
   output logic        w_bus_err_o
);

   wb_state_t   r_state;
   logic        r_committed;
   logic [4:0]  r_rf_rd;
   logic [31:0] r_rf_value;
   logic        r_rf_write;

   logic        w_active;
   logic        w_commit;
   logic        w_abort;
   logic        w_stall;
   logic        w_timeout;
   logic [31:0] w_load_value;
   logic [31:0] w_rd_next;
   logic [29:0] w_unused_addr;

   assign w_unused_addr = w_dm_addr_i[31:2];

`ifdef URV_WB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] r_cnt;
   logic             r_bus_err;

   // Abort fires in the TIMEOUT_CYCLES-th consecutive wait cycle.
   assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign w_bus_err_o = r_bus_err;
`else
   logic [7:0] w_unused_timeout;
   assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
   assign w_timeout        = 1'b0;
   assign w_bus_err_o      = 1'b0;
`endif

   urv_load_align u_load_align (
      .i_fun   (w_fun_i),
      .i_addr  (w_dm_addr_i[1:0]),
      .i_data  (dm_data_l_i),
      .o_value (w_load_value)
   );

   assign w_active = w_valid_i & ~r_committed;

   always_comb begin
      w_commit = 1'b0;
      w_abort  = 1'b0;
      w_stall  = 1'b0;
      case (r_state)
         WB_IDLE: begin
            if (w_active) begin
               if (w_load_i) begin
                  w_commit = dm_load_done_i;
                  w_stall  = ~dm_load_done_i;
               end else if (w_store_i) begin
                  w_commit = dm_store_done_i;
                  w_stall  = ~dm_store_done_i;
               end else begin
                  w_commit = 1'b1;
               end
            end
         end
         WB_WAIT_LOAD: begin
            w_commit = dm_load_done_i | w_timeout;
            w_abort  = ~dm_load_done_i & w_timeout;
            w_stall  = ~w_commit;
         end
         WB_WAIT_STORE: begin
            w_commit = dm_store_done_i | w_timeout;
            w_abort  = ~dm_store_done_i & w_timeout;
            w_stall  = ~w_commit;
         end
         default: begin
            w_commit = 1'b0;
         end
      endcase
   end

   always_comb begin
      w_rd_next = w_rd_value_i;
      if (w_load_i) begin
         w_rd_next = w_load_value;
      end else begin
         case (w_rd_source_i)
            RD_SOURCE_SHIFTER:  w_rd_next = w_rd_shifter_i;
            RD_SOURCE_MULTIPLY: w_rd_next = w_rd_multiply_i;
            default:            w_rd_next = w_rd_value_i;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= WB_IDLE;
         r_committed <= 1'b0;
         r_rf_rd     <= 5'd0;
         r_rf_value  <= 32'd0;
         r_rf_write  <= 1'b0;
`ifdef URV_WB_TIMEOUT_EN
         r_cnt       <= '0;
         r_bus_err   <= 1'b0;
`endif
      end else begin
         r_rf_write <= 1'b0;
`ifdef URV_WB_TIMEOUT_EN
         r_bus_err  <= w_abort;
`endif
         if (w_commit) begin
            r_rf_rd    <= w_rd_i;
            r_rf_value <= w_rd_next;
            r_rf_write <= w_rd_write_i & (w_rd_i != 5'd0) & ~w_store_i & ~w_abort;
         end

         // A deasserted x_stall_i means the slot gets a new instruction next cycle.
         if (!x_stall_i) begin
            r_committed <= 1'b0;
         end else if (w_commit) begin
            r_committed <= 1'b1;
         end

         case (r_state)
            WB_IDLE: begin
               if (w_active && w_load_i && !dm_load_done_i) begin
                  r_state <= WB_WAIT_LOAD;
               end else if (w_active && w_store_i && !dm_store_done_i) begin
                  r_state <= WB_WAIT_STORE;
               end
`ifdef URV_WB_TIMEOUT_EN
               r_cnt <= '0;
`endif
            end
            WB_WAIT_LOAD, WB_WAIT_STORE: begin
               if (w_commit) begin
                  r_state <= WB_IDLE;
               end
`ifdef URV_WB_TIMEOUT_EN
               r_cnt <= w_commit ? '0 : r_cnt + 1'b1;
`endif
            end
            default: begin
               r_state <= WB_IDLE;
            end
         endcase
      end
   end

   assign w_stall_req_o = w_stall;
   assign rf_rd_o       = r_rf_rd;
   assign rf_rd_value_o = r_rf_value;
   assign rf_rd_write_o = r_rf_write;

endmodule

// File: tb/tb_urv_writeback.sv
// Directed bench for urv_writeback: ALU/shift/mul commits, load alignment, waits, hold, timeout, reset mid-wait.
module tb_urv_writeback;
   import urv_writeback_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        x_stall_i;
   logic        w_valid_i;
   logic        w_load_i;
   logic        w_store_i;
   logic [2:0]  w_fun_i;
   logic [4:0]  w_rd_i;
   logic        w_rd_write_i;
   logic [1:0]  w_rd_source_i;
   logic [31:0] w_rd_value_i;
   logic [31:0] w_rd_shifter_i;
   logic [31:0] w_rd_multiply_i;
   logic [31:0] w_dm_addr_i;
   logic [31:0] dm_data_l_i;
   logic        dm_load_done_i;
   logic        dm_store_done_i;
   logic        w_stall_req_o;
   logic [4:0]  rf_rd_o;
   logic [31:0] rf_rd_value_o;
   logic        rf_rd_write_o;
   logic        w_bus_err_o;

   int n_chk = 0;
   int n_err = 0;
   int pulses;
   int edges;
   bit seen;

   always #5 clk_i = ~clk_i;

   urv_writeback #(.TIMEOUT_CYCLES(8)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .x_stall_i       (x_stall_i),
      .w_valid_i       (w_valid_i),
      .w_load_i        (w_load_i),
      .w_store_i       (w_store_i),
      .w_fun_i         (w_fun_i),
      .w_rd_i          (w_rd_i),
      .w_rd_write_i    (w_rd_write_i),
      .w_rd_source_i   (w_rd_source_i),
      .w_rd_value_i    (w_rd_value_i),
      .w_rd_shifter_i  (w_rd_shifter_i),
      .w_rd_multiply_i (w_rd_multiply_i),
      .w_dm_addr_i     (w_dm_addr_i),
      .dm_data_l_i     (dm_data_l_i),
      .dm_load_done_i  (dm_load_done_i),
      .dm_store_done_i (dm_store_done_i),
      .w_stall_req_o   (w_stall_req_o),
      .rf_rd_o         (rf_rd_o),
      .rf_rd_value_o   (rf_rd_value_o),
      .rf_rd_write_o   (rf_rd_write_o),
      .w_bus_err_o     (w_bus_err_o)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic idle_inputs();
      w_valid_i       = 1'b0;
      w_load_i        = 1'b0;
      w_store_i       = 1'b0;
      dm_load_done_i  = 1'b0;
      dm_store_done_i = 1'b0;
      x_stall_i       = 1'b0;
   endtask

   task automatic alu_op(input string tag, input logic [4:0] rd, input logic [1:0] src,
                         input logic [31:0] exp_val, input logic exp_wr);
      w_valid_i     = 1'b1;
      w_load_i      = 1'b0;
      w_store_i     = 1'b0;
      w_rd_i        = rd;
      w_rd_write_i  = 1'b1;
      w_rd_source_i = src;
      x_stall_i     = 1'b0;
      #1 check({tag, "_stall"}, 32'(w_stall_req_o), 32'd0);
      step();
      check({tag, "_wr"}, 32'(rf_rd_write_o), 32'(exp_wr));
      if (exp_wr) begin
         check({tag, "_rd"}, 32'(rf_rd_o), 32'(rd));
         check({tag, "_val"}, rf_rd_value_o, exp_val);
      end
      w_valid_i = 1'b0;
   endtask

   task automatic load_now(input string tag, input logic [2:0] fun, input logic [1:0] addr,
                           input logic [31:0] data, input logic [31:0] exp_val);
      w_valid_i      = 1'b1;
      w_load_i       = 1'b1;
      w_store_i      = 1'b0;
      w_fun_i        = fun;
      w_dm_addr_i    = {30'h0000_1000, addr};
      dm_data_l_i    = data;
      dm_load_done_i = 1'b1;
      w_rd_i         = 5'd9;
      w_rd_write_i   = 1'b1;
      x_stall_i      = 1'b0;
      #1 check({tag, "_stall"}, 32'(w_stall_req_o), 32'd0);
      step();
      check({tag, "_wr"}, 32'(rf_rd_write_o), 32'd1);
      check({tag, "_val"}, rf_rd_value_o, exp_val);
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_i           = 1'b1;
      idle_inputs();
      w_fun_i         = LDST_L;
      w_rd_i          = 5'd0;
      w_rd_write_i    = 1'b0;
      w_rd_source_i   = RD_SOURCE_ALU;
      w_rd_value_i    = 32'd0;
      w_rd_shifter_i  = 32'd0;
      w_rd_multiply_i = 32'd0;
      w_dm_addr_i     = 32'd0;
      dm_data_l_i     = 32'd0;
      step();
      step();
      check("rst_wr", 32'(rf_rd_write_o), 32'd0);
      check("rst_rd", 32'(rf_rd_o), 32'd0);
      check("rst_val", rf_rd_value_o, 32'd0);
      check("rst_err", 32'(w_bus_err_o), 32'd0);
      check("rst_stall", 32'(w_stall_req_o), 32'd0);
      rst_i = 1'b0;
      step();

      // Plain single-cycle commits for each rd source, plus the x0 case.
      w_rd_value_i    = 32'h1234_5678;
      w_rd_shifter_i  = 32'hA5A5_0001;
      w_rd_multiply_i = 32'h0F0F_F0F0;
      alu_op("alu", 5'd5, RD_SOURCE_ALU, 32'h1234_5678, 1'b1);
      step();
      check("alu_single", 32'(rf_rd_write_o), 32'd0);
      alu_op("shf", 5'd7, RD_SOURCE_SHIFTER, 32'hA5A5_0001, 1'b1);
      alu_op("mul", 5'd31, RD_SOURCE_MULTIPLY, 32'h0F0F_F0F0, 1'b1);
      alu_op("csr", 5'd2, RD_SOURCE_CSR, 32'h1234_5678, 1'b1);
      alu_op("x0", 5'd0, RD_SOURCE_ALU, 32'h0, 1'b0);
      step();

      // Load alignment with done in the issue cycle.
      load_now("lb3",  LDST_B,  2'd3, 32'h80FF_FFFF, 32'hFFFF_FF80);
      load_now("lbu3", LDST_BU, 2'd3, 32'h80FF_FFFF, 32'h0000_0080);
      load_now("lb1",  LDST_B,  2'd1, 32'hFFFF_7FFF, 32'h0000_007F);
      load_now("lh2",  LDST_H,  2'd2, 32'h8001_0000, 32'hFFFF_8001);
      load_now("lh0",  LDST_H,  2'd0, 32'h0000_7ABC, 32'h0000_7ABC);
      load_now("lw",   LDST_L,  2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

      // LHU with done three cycles late.
      w_valid_i      = 1'b1;
      w_load_i       = 1'b1;
      w_fun_i        = LDST_HU;
      w_dm_addr_i    = 32'h0000_2002;
      dm_data_l_i    = 32'hDEAD_DEAD;
      w_rd_i         = 5'd14;
      w_rd_write_i   = 1'b1;
      x_stall_i      = 1'b1;
      #1 check("lhu_stall0", 32'(w_stall_req_o), 32'd1);
      step();
      check("lhu_stall1", 32'(w_stall_req_o), 32'd1);
      check("lhu_nowr1", 32'(rf_rd_write_o), 32'd0);
      step();
      check("lhu_stall2", 32'(w_stall_req_o), 32'd1);
      check("lhu_nowr2", 32'(rf_rd_write_o), 32'd0);
      dm_load_done_i = 1'b1;
      dm_data_l_i    = 32'hBEEF_0000;
      x_stall_i      = 1'b0;
      #1 check("lhu_done_stall", 32'(w_stall_req_o), 32'd0);
      step();
      check("lhu_wr", 32'(rf_rd_write_o), 32'd1);
      check("lhu_rd", 32'(rf_rd_o), 32'd14);
      check("lhu_val", rf_rd_value_o, 32'h0000_BEEF);
      idle_inputs();
      step();
      check("lhu_once", 32'(rf_rd_write_o), 32'd0);

      // Committed ALU op held by the pipeline for several cycles: one write only.
      w_rd_value_i  = 32'hCAFE_0001;
      w_valid_i     = 1'b1;
      w_rd_i        = 5'd12;
      w_rd_write_i  = 1'b1;
      w_rd_source_i = RD_SOURCE_ALU;
      x_stall_i     = 1'b1;
      pulses        = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (rf_rd_write_o) pulses++;
      end
      check("hold_pulses", 32'(pulses), 32'd1);
      check("hold_val", rf_rd_value_o, 32'hCAFE_0001);
      check("hold_stall", 32'(w_stall_req_o), 32'd0);
      idle_inputs();
      step();

      // Store completing immediately never writes the RF.
      w_valid_i       = 1'b1;
      w_store_i       = 1'b1;
      w_rd_i          = 5'd3;
      w_rd_write_i    = 1'b1;
      dm_store_done_i = 1'b1;
      #1 check("st_stall", 32'(w_stall_req_o), 32'd0);
      step();
      check("st_nowr", 32'(rf_rd_write_o), 32'd0);
      idle_inputs();

      // Stray done strobe with an empty slot.
      dm_load_done_i = 1'b1;
      #1 check("stray_stall", 32'(w_stall_req_o), 32'd0);
      step();
      check("stray_nowr", 32'(rf_rd_write_o), 32'd0);
      idle_inputs();
      step();

      // Store whose completion never arrives.
      w_valid_i    = 1'b1;
      w_store_i    = 1'b1;
      w_rd_i       = 5'd3;
      w_rd_write_i = 1'b1;
      x_stall_i    = 1'b1;
      #1 check("to_stall0", 32'(w_stall_req_o), 32'd1);
`ifdef URV_WB_TIMEOUT_EN
      // One IDLE issue cycle plus eight WAIT cycles before the error pulse shows.
      edges = 0;
      seen  = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         step();
         edges++;
         if (w_bus_err_o) seen = 1'b1;
      end
      check("to_edges", 32'(edges), 32'd9);
      check("to_nowr", 32'(rf_rd_write_o), 32'd0);
      check("to_stall_off", 32'(w_stall_req_o), 32'd0);
      step();
      check("to_pulse1", 32'(w_bus_err_o), 32'd0);
      idle_inputs();
      step();
`else
      for (int i = 0; i < 20; i++) begin
         step();
      end
      check("to_still_stall", 32'(w_stall_req_o), 32'd1);
      check("to_no_err", 32'(w_bus_err_o), 32'd0);
      dm_store_done_i = 1'b1;
      x_stall_i       = 1'b0;
      #1 check("to_done_stall", 32'(w_stall_req_o), 32'd0);
      step();
      check("to_st_nowr", 32'(rf_rd_write_o), 32'd0);
      idle_inputs();
      step();
`endif

      // Reset while waiting on a load; a late done must be ignored.
      w_valid_i    = 1'b1;
      w_load_i     = 1'b1;
      w_fun_i      = LDST_L;
      w_dm_addr_i  = 32'h0000_3000;
      w_rd_i       = 5'd20;
      w_rd_write_i = 1'b1;
      x_stall_i    = 1'b1;
      step();
      step();
      check("rw_stall", 32'(w_stall_req_o), 32'd1);
      rst_i = 1'b1;
      idle_inputs();
      step();
      rst_i = 1'b0;
      check("rw_rst_wr", 32'(rf_rd_write_o), 32'd0);
      check("rw_rst_stall", 32'(w_stall_req_o), 32'd0);
      dm_load_done_i = 1'b1;
      dm_data_l_i    = 32'h5555_AAAA;
      #1 check("rw_late_stall", 32'(w_stall_req_o), 32'd0);
      step();
      check("rw_late_nowr", 32'(rf_rd_write_o), 32'd0);
      idle_inputs();
      step();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
